// File: rtl/id_ex_decode_pkg.sv
// Shared RV32I decode definitions: ALU op codes, opcodes, operand-A selects
// and the ID/EX stage register layout.
package id_ex_decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_XOR  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_BEQ  = 4'b1010,
    ALU_BNE  = 4'b1011,
    ALU_BLT  = 4'b1100,
    ALU_BGE  = 4'b1101,
    ALU_BLTU = 4'b1110,
    ALU_BGEU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'b00,
    SRC_A_PC   = 2'b01,
    SRC_A_ZERO = 2'b10
  } src_a_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    alu_op_e     alu;
    src_a_e      src_a;
    logic        src_b;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jump;
  } stage_t;

  // All-zero is exactly the bubble: ADD and RS1 both encode as zero.
  localparam stage_t STAGE_BUBBLE = '0;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_decode_imm_gen.sv
// Combinational immediate extraction; format chosen from the opcode,
// zero for formats without an immediate.
module imm_gen
  import id_ex_decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {instr[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_decode.sv
// ID/EX pipeline stage: decodes an RV32I word into ALU/control fields and
// registers them, with flush > stall > load priority.
module id_ex_decode
  import id_ex_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [3:0]  alucontrol,
  output logic [1:0]  alusrc_a,
  output logic        alusrc_b,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] pc_out,
  output logic        regwrite,
  output logic        memread,
  output logic        memwrite,
  output logic        branch,
  output logic        jump,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_raw;
  logic        bad;
  stage_t      dec;
  stage_t      stage;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  imm_gen u_imm_gen (
    .instr (instr),
    .imm   (imm_raw)
  );

  always_comb begin
    dec       = STAGE_BUBBLE;
    bad       = 1'b0;
    dec.valid = 1'b1;
    dec.pc    = pc;
    dec.rs1   = instr[19:15];
    dec.rs2   = instr[24:20];
    dec.rd    = instr[11:7];
    dec.imm   = imm_raw;
    case (opcode)
      OPC_OP: begin
        dec.regwrite = 1'b1;
        if (funct7 == F7_BASE)                       dec.alu = alu_from_f3(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) dec.alu = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) dec.alu = ALU_SRA;
        else                                         bad = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.regwrite = 1'b1;
        dec.src_b    = 1'b1;
        dec.alu      = alu_from_f3(funct3);
        // Shift-amount encodings reuse imm[11:5] as a funct7 qualifier.
        if (funct3 == 3'b001 && funct7 != F7_BASE) bad = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)       dec.alu = ALU_SRA;
          else if (funct7 != F7_BASE) bad = 1'b1;
        end
      end
      OPC_LOAD: begin
        dec.src_b    = 1'b1;
        dec.memread  = 1'b1;
        dec.regwrite = 1'b1;
      end
      OPC_STORE: begin
        dec.src_b    = 1'b1;
        dec.memwrite = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        case (funct3)
          3'b000:  dec.alu = ALU_BEQ;
          3'b001:  dec.alu = ALU_BNE;
          3'b100:  dec.alu = ALU_BLT;
          3'b101:  dec.alu = ALU_BGE;
          3'b110:  dec.alu = ALU_BLTU;
          3'b111:  dec.alu = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.src_a    = (opcode == OPC_LUI) ? SRC_A_ZERO : SRC_A_PC;
        dec.src_b    = 1'b1;
        dec.regwrite = 1'b1;
      end
      OPC_JAL: begin
        dec.src_a    = SRC_A_PC;
        dec.src_b    = 1'b1;
        dec.jump     = 1'b1;
        dec.regwrite = 1'b1;
      end
      OPC_JALR: begin
        dec.src_b    = 1'b1;
        dec.jump     = 1'b1;
        dec.regwrite = 1'b1;
        if (funct3 != 3'b000) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = STAGE_BUBBLE;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
      dec.pc      = pc;
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.rd      = instr[11:7];
    end
    if (!in_valid) dec = STAGE_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      stage <= STAGE_BUBBLE;
    else if (flush)  stage <= STAGE_BUBBLE;
    else if (!stall) stage <= dec;
  end

  assign out_valid  = stage.valid;
  assign illegal    = stage.illegal;
  assign alucontrol = stage.alu;
  assign alusrc_a   = stage.src_a;
  assign alusrc_b   = stage.src_b;
  assign imm        = stage.imm;
  assign rs1        = stage.rs1;
  assign rs2        = stage.rs2;
  assign rd         = stage.rd;
  assign pc_out     = stage.pc;
  assign regwrite   = stage.regwrite;
  assign memread    = stage.memread;
  assign memwrite   = stage.memwrite;
  assign branch     = stage.branch;
  assign jump       = stage.jump;

endmodule
